// File: rtl/hazard_sequencer_if.sv
// Hazard/stall control bundle between the core datapath
// and the hazard sequencer.
interface hazard_sequencer_if;
  logic        dcache_miss;
  logic        icache_miss;
  logic        id_ex_memread;
  logic [3:0]  id_ex_rd;
  logic [3:0]  if_id_rs;
  logic [3:0]  if_id_rt;
  logic        rs_used;
  logic        rt_used;
  logic        branch_taken;
  logic        hlt_id;
  logic        pc_wen;
  logic        if_id_wen;
  logic        id_ex_wen;
  logic        ex_mem_wen;
  logic        mem_wb_wen;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        halted;
  logic [15:0] stall_count;

  modport master (
    input  dcache_miss, icache_miss,
    input  id_ex_memread, id_ex_rd,
    input  if_id_rs, if_id_rt,
    input  rs_used, rt_used,
    input  branch_taken, hlt_id,
    output pc_wen, if_id_wen, id_ex_wen,
    output ex_mem_wen, mem_wb_wen,
    output if_id_flush, id_ex_flush,
    output halted, stall_count
  );

  modport slave (
    output dcache_miss, icache_miss,
    output id_ex_memread, id_ex_rd,
    output if_id_rs, if_id_rt,
    output rs_used, rt_used,
    output branch_taken, hlt_id,
    input  pc_wen, if_id_wen, id_ex_wen,
    input  ex_mem_wen, mem_wb_wen,
    input  if_id_flush, id_ex_flush,
    input  halted, stall_count
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Five-stage pipeline stall/flush sequencer: cache freezes,
// load-use stalls, branch flushes and halt drain.
module hazard_sequencer #(
  parameter int DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  hazard_sequencer_if.master bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0] wen;
  logic [1:0] flush;
  logic [15:0] stalls;
  logic rs_hit, rt_hit, luse;

  assign rs_hit = bus.rs_used
                & (bus.id_ex_rd == bus.if_id_rs);
  assign rt_hit = bus.rt_used
                & (bus.id_ex_rd == bus.if_id_rt);
  assign luse = bus.id_ex_memread
              & (bus.id_ex_rd != 4'd0)
              & (rs_hit | rt_hit);

  // wen = {pc, if_id, id_ex, ex_mem, mem_wb}
  // flush = {if_id, id_ex}
  always_comb begin
    wen      = 5'b00000;
    flush    = 2'b00;
    state_nx = state;
    cnt_nx   = cnt;
    if (rst) begin
      unique case (state)
        RUN: begin
          priority case (1'b1)
            bus.dcache_miss: ;
            bus.icache_miss: begin
              wen   = 5'b01111;
              flush = 2'b10;
            end
            luse: begin
              wen   = 5'b00111;
              flush = 2'b01;
            end
            bus.hlt_id: begin
              wen      = 5'b00111;
              state_nx = DRAIN;
              cnt_nx   = CW'(DRAIN_CYCLES);
            end
            bus.branch_taken: begin
              wen   = 5'b11111;
              flush = 2'b10;
            end
            default: wen = 5'b11111;
          endcase
        end
        DRAIN: begin
          wen   = {2'b00, {3{~bus.dcache_miss}}};
          flush = 2'b01;
          if (!bus.dcache_miss) begin
            if (cnt == CW'(1)) state_nx = HALTED;
            else cnt_nx = cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      cnt    <= '0;
      stalls <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!wen[4] && state != HALTED
          && stalls != 16'hFFFF)
        stalls <= stalls + 16'd1;
    end
  end

  assign bus.pc_wen      = wen[4];
  assign bus.if_id_wen   = wen[3];
  assign bus.id_ex_wen   = wen[2];
  assign bus.ex_mem_wen  = wen[1];
  assign bus.mem_wb_wen  = wen[0];
  assign bus.if_id_flush = flush[1];
  assign bus.id_ex_flush = flush[0];
  assign bus.halted      = (state == HALTED);
  assign bus.stall_count = stalls;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: cycle model
// plus directed literal checks.
module tb_hazard_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_sequencer_if bus ();

  hazard_sequencer #(.DRAIN_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  // mode 0 = running, 1 = draining, 2 = stopped
  int mode = 0;
  int left = 0;
  int stalls = 0;

  function automatic logic [6:0] outs();
    return {bus.pc_wen, bus.if_id_wen, bus.id_ex_wen,
            bus.ex_mem_wen, bus.mem_wb_wen,
            bus.if_id_flush, bus.id_ex_flush};
  endfunction

  function automatic logic lu();
    logic a, b;
    a = bus.rs_used && bus.id_ex_rd == bus.if_id_rs;
    b = bus.rt_used && bus.id_ex_rd == bus.if_id_rt;
    return bus.id_ex_memread && bus.id_ex_rd != 0
           && (a || b);
  endfunction

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl}
  function automatic logic [6:0] model_out();
    logic d;
    d = bus.dcache_miss;
    if (!rst || mode == 2) return 7'b0;
    if (mode == 1) return {2'b00, {3{~d}}, 2'b01};
    if (d) return 7'b0;
    if (bus.icache_miss) return 7'b0111110;
    if (lu()) return 7'b0011101;
    if (bus.hlt_id) return 7'b0011100;
    if (bus.branch_taken) return 7'b1111110;
    return 7'b1111100;
  endfunction

  function automatic logic model_pc();
    logic [6:0] o;
    o = model_out();
    return o[6];
  endfunction

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= 0;
      left <= 0;
      stalls <= 0;
    end else begin
      if (!model_pc() && mode != 2 && stalls < 65535)
        stalls <= stalls + 1;
      if (mode == 0) begin
        if (bus.hlt_id && !bus.dcache_miss
            && !bus.icache_miss && !lu()) begin
          mode <= 1;
          left <= 3;
        end
      end else if (mode == 1 && !bus.dcache_miss) begin
        if (left == 1) mode <= 2;
        else left <= left - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_outs", {25'd0, outs()}, {25'd0, model_out()});
    chk("model_halted", {31'd0, bus.halted},
        {31'd0, (rst && mode == 2)});
    chk("model_stalls", {16'd0, bus.stall_count}, stalls);
  end

  task automatic idle();
    bus.dcache_miss   = 1'b0;
    bus.icache_miss   = 1'b0;
    bus.id_ex_memread = 1'b0;
    bus.id_ex_rd      = 4'd0;
    bus.if_id_rs      = 4'd0;
    bus.if_id_rt      = 4'd0;
    bus.rs_used       = 1'b0;
    bus.rt_used       = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.hlt_id        = 1'b0;
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    cyc(2);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    cyc(2);
    chk("rst_outs", {25'd0, outs()}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_stalls", {16'd0, bus.stall_count}, 32'd0);
    rst = 1'b1;
    #1;
    chk("idle_outs", {25'd0, outs()}, 32'h7C);
    chk("idle_stalls", {16'd0, bus.stall_count}, 32'd0);
    cyc(2);

    // load-use on rs
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd = 4'd5;
    bus.if_id_rs = 4'd5;
    bus.rs_used = 1'b1;
    #1;
    chk("luse_outs", {25'd0, outs()}, 32'h1D);
    cyc(1);
    idle();
    #1;
    chk("luse_count", {16'd0, bus.stall_count}, 32'd1);
    chk("luse_clear", {25'd0, outs()}, 32'h7C);
    // rd = 0 never stalls
    bus.id_ex_memread = 1'b1;
    bus.if_id_rs = 4'd0;
    bus.rs_used = 1'b1;
    #1;
    chk("rd0_outs", {25'd0, outs()}, 32'h7C);
    cyc(1);
    // rt hit with branch: stall wins
    bus.id_ex_rd = 4'd7;
    bus.if_id_rt = 4'd7;
    bus.rt_used = 1'b1;
    bus.rs_used = 1'b0;
    bus.branch_taken = 1'b1;
    #1;
    chk("luse_br", {25'd0, outs()}, 32'h1D);
    cyc(1);
    // rt match without rt_used: branch flush
    bus.rt_used = 1'b0;
    #1;
    chk("br_only", {25'd0, outs()}, 32'h7E);
    cyc(1);
    idle();
    bus.icache_miss = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    chk("ic_br", {25'd0, outs()}, 32'h3E);
    cyc(1);
    idle();
    #1;
    chk("count_3", {16'd0, bus.stall_count}, 32'd3);

    // asynchronous reset mid-run
    #2;
    rst = 1'b0;
    #1;
    chk("async_outs", {25'd0, outs()}, 32'd0);
    chk("async_cnt", {16'd0, bus.stall_count}, 32'd0);
    cyc(1);
    rst = 1'b1;
    cyc(1);

    // 4-cycle dcache miss over a taken branch
    bus.dcache_miss = 1'b1;
    bus.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dc_frozen", {25'd0, outs()}, 32'd0);
      cyc(1);
    end
    bus.dcache_miss = 1'b0;
    #1;
    chk("dc_br_after", {25'd0, outs()}, 32'h7E);
    cyc(1);
    idle();
    #1;
    chk("dc_count", {16'd0, bus.stall_count}, 32'd4);

    // halt, no misses
    do_reset();
    bus.hlt_id = 1'b1;
    #1;
    chk("hlt_accept", {25'd0, outs()}, 32'h1C);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_outs", {25'd0, outs()}, 32'h1D);
      chk("drain_halt", {31'd0, bus.halted}, 32'd0);
      cyc(1);
    end
    chk("halted_4", {31'd0, bus.halted}, 32'd1);
    chk("halt_cnt", {16'd0, bus.stall_count}, 32'd4);
    cyc(20);
    chk("halt_outs", {25'd0, outs()}, 32'd0);
    chk("halt_cnt20", {16'd0, bus.stall_count}, 32'd4);

    // halt with 2 dcache-miss cycles in drain
    do_reset();
    bus.hlt_id = 1'b1;
    cyc(2);
    bus.dcache_miss = 1'b1;
    #1;
    chk("drain_dc", {25'd0, outs()}, 32'h01);
    cyc(2);
    bus.dcache_miss = 1'b0;
    cyc(1);
    chk("delay_e5", {31'd0, bus.halted}, 32'd0);
    cyc(1);
    chk("delay_e6", {31'd0, bus.halted}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_halted2", {31'd0, bus.halted}, 32'd0);
    cyc(1);
    rst = 1'b1;
    idle();
    #1;
    chk("run_again", {25'd0, outs()}, 32'h7C);
    cyc(1);

    // stall counter saturation
    do_reset();
    bus.icache_miss = 1'b1;
    cyc(70000);
    chk("sat_ffff", {16'd0, bus.stall_count}, 32'hFFFF);
    cyc(3);
    chk("sat_hold", {16'd0, bus.stall_count}, 32'hFFFF);
    idle();
    #1;
    chk("sat_outs", {25'd0, outs()}, 32'h7C);
    cyc(1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
